// File: rtl/bitserial_mult_array.sv
// Bit-serial sign-magnitude multiplier array: one serial weight broadcast to LANES
// parallel neuron operands, producing rounded, saturated Q(INT_W).(FRAC_W) products.
module bitserial_mult_array #(
  parameter int unsigned INT_W  = 5,
  parameter int unsigned FRAC_W = 10,
  parameter int unsigned LANES  = 4,
  parameter int unsigned ROUND  = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  weight_bit,
  input  logic [LANES*(1+INT_W+FRAC_W)-1:0]     neurons,
  output logic                                  busy,
  output logic                                  out_valid,
  output logic [LANES*(1+INT_W+FRAC_W)-1:0]     out,
  output logic [LANES-1:0]                      sat
);

  localparam int unsigned MAG_W  = INT_W + FRAC_W;
  localparam int unsigned DATA_W = 1 + MAG_W;
  localparam int unsigned ACC_W  = 2 * MAG_W;
  localparam int unsigned R_W    = ACC_W - FRAC_W + 1;
  localparam int unsigned CNT_W  = (MAG_W > 2) ? $clog2(MAG_W - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAG_W - 2);

  typedef enum logic [1:0] {ST_IDLE, ST_MAG, ST_SGN} state_e;

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [MAG_W-1:0]              mag_q [LANES];
  logic [MAG_W-1:0]              mag_d [LANES];
  logic [ACC_W-1:0]              acc_q [LANES];
  logic [ACC_W-1:0]              acc_d [LANES];
  logic [LANES-1:0]              nsgn_q, nsgn_d;
  logic [LANES*DATA_W-1:0]       out_q, out_d;
  logic [LANES-1:0]              sat_q, sat_d;
  logic                          valid_q, valid_d;
  logic                          busy_q, busy_d;

  // Next-state and datapath: MSB-first shift-add, then sign/round/saturate in SGN.
  always_comb begin : next_state
    logic [R_W-1:0]   r;
    logic [MAG_W-1:0] m;
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    nsgn_d  = nsgn_q;
    out_d   = out_q;
    sat_d   = sat_q;
    valid_d = 1'b0;
    r       = '0;
    m       = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int i = 0; i < int'(LANES); i++) begin
            mag_d[i]  = neurons[i*DATA_W +: MAG_W];
            nsgn_d[i] = neurons[i*DATA_W + MAG_W];
            acc_d[i]  = weight_bit ? ACC_W'(neurons[i*DATA_W +: MAG_W]) : '0;
          end
          cnt_d   = '0;
          state_d = ST_MAG;
        end
      end
      ST_MAG: begin
        for (int i = 0; i < int'(LANES); i++) begin
          acc_d[i] = {acc_q[i][ACC_W-2:0], 1'b0} + (weight_bit ? ACC_W'(mag_q[i]) : '0);
        end
        if (cnt_q == CNT_LAST) begin
          state_d = ST_SGN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SGN: begin
        for (int i = 0; i < int'(LANES); i++) begin
          r = R_W'(acc_q[i] >> FRAC_W)
            + ((ROUND != 0) ? R_W'(acc_q[i][FRAC_W-1]) : R_W'(0));
          sat_d[i] = |r[R_W-1:MAG_W];
          m = sat_d[i] ? '1 : r[MAG_W-1:0];
          // Zero magnitude always carries a positive sign.
          out_d[i*DATA_W +: DATA_W] = {(nsgn_q[i] ^ weight_bit) & (|m), m};
        end
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      nsgn_q  <= '0;
      out_q   <= '0;
      sat_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < int'(LANES); i++) begin
        mag_q[i] <= '0;
        acc_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nsgn_q  <= nsgn_d;
      out_q   <= out_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      for (int i = 0; i < int'(LANES); i++) begin
        mag_q[i] <= mag_d[i];
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out       = out_q;
  assign sat       = sat_q;

endmodule
